// File: rtl/ram_rd_stream.sv
// ram_rd_stream
//   Read-side sequencer for a single-port synchronous RAM with a 1-cycle
//   registered read. It accepts a (start_addr, len) command and issues
//   back-to-back RAM reads. It turns the fixed read latency into a
//   valid/ready stream with full backpressure.
//
//   Flow control: a read is issued only while the words already owed to the
//   consumer fit in the 2-entry skid FIFO. "Owed" means words in the FIFO plus
//   the word in flight from the RAM, minus the word popped this cycle. Because
//   of this rule the FIFO can never overflow.
//
//   The word in flight is presented on the stream in the same cycle that
//   ram_q carries it (bypass). If that word is not taken, it is written into
//   the FIFO. It then stays at the stream head, so out_data does not change
//   while the stream is stalled.
//
// Optional feature (macro RAM_RD_STREAM_LAST_EN):
//   When the macro is defined, the module has an extra output out_last. It is
//   high while the final word of the burst is on the stream.
//
// Ports
//   clk, rst             clock (posedge); asynchronous active-high reset
//   start, start_addr    command strobe and first word address
//   len                  number of words (0 -> done pulse only)
//   busy, done           command in progress / one-cycle completion pulse
//   ram_addr, ram_en     RAM read port (one read per cycle while ram_en)
//   ram_we, ram_d        write side, tied off
//   ram_q                RAM read data, valid the cycle after ram_en
//   out_data, out_valid  output stream
//   out_ready            consumer ready
//   out_last             (macro only) final word marker
module ram_rd_stream #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14,
  parameter int LWIDTH = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [LWIDTH-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
`ifdef RAM_RD_STREAM_LAST_EN
  output logic              out_last,
`endif
  input  logic              out_ready
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] addr;
  logic [LWIDTH-1:0] rd_left;
  logic [LWIDTH-1:0] out_left;
  logic              inflight;
  logic              done_q;
  logic [DWIDTH-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;

  logic              pop, issue, accept, zero_cmd, last_pop;
  logic              fifo_push, fifo_pop;
  logic [2:0]        owed;

  // Stream head: the FIFO first, otherwise the word arriving from the RAM.
  // ram_q is looked at only while a read is in flight, because it holds stale
  // data at all other times.
  assign out_valid = (fifo_cnt != 2'd0) | inflight;
  assign out_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] :
                     (inflight ? ram_q : '0);
  assign pop       = out_valid & out_ready;

  // Words still owed after this cycle's pop. This equals the next FIFO count,
  // because the in-flight word either leaves via bypass or lands in the FIFO.
  assign owed      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign fifo_push = inflight & ~(pop & (fifo_cnt == 2'd0));
  assign fifo_pop  = pop & (fifo_cnt != 2'd0);

  assign busy      = (state == RUN);
  assign done      = done_q;
  assign ram_addr  = addr;
  assign ram_en    = issue;
  assign ram_we    = 1'b0;
  assign ram_d     = '0;

`ifdef RAM_RD_STREAM_LAST_EN
  assign out_last  = (state == RUN) & out_valid & (out_left == LWIDTH'(1));
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    zero_cmd   = 1'b0;
    last_pop   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            zero_cmd   = 1'b1;
          end
        end
      end
      RUN: begin
        issue    = (rd_left != '0) && (owed <= 3'd1);
        last_pop = pop && (out_left == LWIDTH'(1));
        if (last_pop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      rd_left  <= '0;
      out_left <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      state    <= state_next;
      done_q   <= zero_cmd | last_pop;
      inflight <= issue;
      if (accept) begin
        addr     <= start_addr;
        rd_left  <= len;
        out_left <= len;
      end else begin
        if (issue) begin
          addr    <= addr + 1'b1;   // wraps naturally at 2^AWIDTH
          rd_left <= rd_left - 1'b1;
        end
        if (pop) out_left <= out_left - 1'b1;
      end
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= ram_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= owed[1:0];
    end
  end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed testbench for ram_rd_stream.
//   The main instance uses AWIDTH=14 with mem[i]=i.
//   The wrap instance uses AWIDTH=4 with mem[i]=0xA0+i.
module tb_ram_rd_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        start = 1'b0;
  logic [13:0] start_addr = '0;
  logic [14:0] len = '0;
  logic        busy, done, ram_en, ram_we, out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] ram_addr;
  logic [31:0] ram_d, ram_q, out_data;
  logic [31:0] mem [16384];

  // wrap instance
  logic        w_start = 1'b0;
  logic [3:0]  w_start_addr = '0;
  logic [14:0] w_len = '0;
  logic        w_busy, w_done, w_ram_en, w_ram_we, w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [3:0]  w_ram_addr;
  logic [31:0] w_ram_d, w_ram_q, w_out_data;
  logic [31:0] w_mem [16];

`ifdef RAM_RD_STREAM_LAST_EN
  logic        out_last, w_out_last;
`endif

  int passed = 0;
  int total  = 0;

  ram_rd_stream #(.DWIDTH(32), .AWIDTH(14), .LWIDTH(15)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid),
`ifdef RAM_RD_STREAM_LAST_EN
    .out_last(out_last),
`endif
    .out_ready(out_ready)
  );

  ram_rd_stream #(.DWIDTH(32), .AWIDTH(4), .LWIDTH(15)) w_dut (
    .clk(clk), .rst(rst), .start(w_start), .start_addr(w_start_addr), .len(w_len),
    .busy(w_busy), .done(w_done), .ram_addr(w_ram_addr), .ram_en(w_ram_en),
    .ram_we(w_ram_we), .ram_d(w_ram_d), .ram_q(w_ram_q), .out_data(w_out_data),
    .out_valid(w_out_valid),
`ifdef RAM_RD_STREAM_LAST_EN
    .out_last(w_out_last),
`endif
    .out_ready(w_out_ready)
  );

  // RAM models with a 1-cycle registered read
  always @(posedge clk) if (ram_en)   ram_q   <= mem[ram_addr];
  always @(posedge clk) if (w_ram_en) w_ram_q <= w_mem[w_ram_addr];

  // Entered at the negedge just after the start edge, with out_ready=1.
  // Expects words base..base+n-1, then a done pulse.
  task automatic expect_stream(input logic [31:0] base, input int n, input string tag);
    int got = 0;
    bit fin = 0;
    for (int c = 0; c < 64 && !fin; c++) begin
      #1;
      if (done) begin
        total++;
        if (got !== n) $display("FAIL %s_count got=%0d required=%0d", tag, got, n);
        else passed++;
        fin = 1;
      end else begin
        if (out_valid && out_ready) begin
          total++;
          if (out_data !== base + got)
            $display("FAIL %s_data word=%0d got=%h required=%h", tag, got, out_data, base + got);
          else passed++;
          $display("%s word %0d data=%h", tag, got, out_data);
          got++;
        end
        @(negedge clk);
      end
    end
    if (!fin) begin
      total++;
      $display("FAIL %s_timeout got=%0d words required=%0d", tag, got, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (busy !== 0 || done !== 0 || ram_en !== 0 || ram_addr !== 0 || out_valid !== 0 ||
          out_data !== 0 || ram_we !== 0 || ram_d !== 0 || w_ram_en !== 0 || w_out_valid !== 0)
        $display("FAIL reset busy=%b done=%b ram_en=%b ram_addr=%h out_valid=%b out_data=%h required all 0",
                 busy, done, ram_en, ram_addr, out_valid, out_data);
      else passed++;
      $display("reset cycle %0d checked", i);
    end
    rst = 1'b0;
  endtask

  task automatic test_burst();
    @(negedge clk); start = 1; start_addr = 14'h10; len = 15'd8; out_ready = 1;
    @(negedge clk); start = 0; #1;
    total++;
    if (busy !== 1 || ram_en !== 1 || ram_addr !== 14'h10 || out_valid !== 0)
      $display("FAIL burst_first busy=%b ram_en=%b ram_addr=%h out_valid=%b required 1 1 0010 0",
               busy, ram_en, ram_addr, out_valid);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1 || out_data !== 32'h10 + k)
        $display("FAIL burst_word k=%0d valid=%b data=%h required 1 %h", k, out_valid, out_data, 32'h10 + k);
      else passed++;
      $display("burst word %0d data=%h", k, out_data);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1 || busy !== 0 || out_valid !== 0)
      $display("FAIL burst_done done=%b busy=%b valid=%b required 1 0 0", done, busy, out_valid);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (done !== 0) $display("FAIL burst_done_pulse done=%b required 0", done);
    else passed++;
  endtask

  task automatic test_backpressure();
    int got = 0;
    bit fin = 0;
    bit held = 0;
    logic [31:0] hold_val = '0;
    @(negedge clk); start = 1; start_addr = 14'h10; len = 15'd6; out_ready = 0;
    @(negedge clk); start = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      out_ready = (c < 4) ? (c % 2 == 0) : (c >= 9);
      #1;
      if (c == 8) begin
        total++;
        if (ram_en !== 0 || out_valid !== 1)
          $display("FAIL bp_credit_stall ram_en=%b valid=%b required 0 1", ram_en, out_valid);
        else passed++;
      end
      if (held) begin
        total++;
        if (out_valid !== 1 || out_data !== hold_val)
          $display("FAIL bp_hold valid=%b data=%h required 1 %h", out_valid, out_data, hold_val);
        else passed++;
      end
      held = 0;
      if (done) begin
        total++;
        if (got !== 6) $display("FAIL bp_count got=%0d required=6", got);
        else passed++;
        fin = 1;
      end else if (out_valid && out_ready) begin
        total++;
        if (out_data !== 32'h10 + got)
          $display("FAIL bp_data word=%0d got=%h required=%h", got, out_data, 32'h10 + got);
        else passed++;
        $display("bp word %0d data=%h cycle=%0d", got, out_data, c);
        got++;
      end else if (out_valid) begin
        held = 1;
        hold_val = out_data;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      total++;
      $display("FAIL bp_timeout got=%0d words required=6", got);
    end
    out_ready = 1;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_addr [4];
    int ai = 0;
    int di = 0;
    bit fin = 0;
    exp_addr[0] = 4'hE; exp_addr[1] = 4'hF; exp_addr[2] = 4'h0; exp_addr[3] = 4'h1;
    @(negedge clk); w_start = 1; w_start_addr = 4'hE; w_len = 15'd4;
    @(negedge clk); w_start = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      #1;
      if (w_ram_en) begin
        total++;
        if (ai >= 4 || w_ram_addr !== exp_addr[ai % 4])
          $display("FAIL wrap_addr issue=%0d got=%h required=%h", ai, w_ram_addr, exp_addr[ai % 4]);
        else passed++;
        ai++;
      end
      if (w_done) begin
        total++;
        if (ai !== 4 || di !== 4) $display("FAIL wrap_count issues=%0d words=%0d required 4 4", ai, di);
        else passed++;
        fin = 1;
      end else if (w_out_valid && w_out_ready) begin
        total++;
        if (w_out_data !== 32'hA0 + exp_addr[di % 4])
          $display("FAIL wrap_data word=%0d got=%h required=%h", di, w_out_data, 32'hA0 + exp_addr[di % 4]);
        else passed++;
        $display("wrap word %0d data=%h", di, w_out_data);
        di++;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      total++;
      $display("FAIL wrap_timeout words=%0d required=4", di);
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk); start = 1; start_addr = 14'h10; len = 15'd0;
    @(negedge clk); start = 0; #1;
    total++;
    if (done !== 1 || busy !== 0 || ram_en !== 0)
      $display("FAIL len0_done done=%b busy=%b ram_en=%b required 1 0 0", done, busy, ram_en);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (done !== 0 || busy !== 0 || ram_en !== 0)
      $display("FAIL len0_after done=%b busy=%b ram_en=%b required 0 0 0", done, busy, ram_en);
    else passed++;
    $display("len0 command done");
  endtask

  task automatic test_start_while_busy();
    @(negedge clk); start = 1; start_addr = 14'h30; len = 15'd2;
    @(negedge clk); start_addr = 14'h50; len = 15'd5;   // start still high while busy
    @(negedge clk); start = 0;
    // ignored command must not disturb the running burst
    #1;
    total++;
    if (out_valid !== 1 || out_data !== 32'h30)
      $display("FAIL busy_start_first valid=%b data=%h required 1 00000030", out_valid, out_data);
    else passed++;
    expect_stream(32'h30, 2, "busy_start");
    @(negedge clk); @(negedge clk); #1;
    total++;
    if (busy !== 0 || ram_en !== 0) $display("FAIL busy_start_idle busy=%b ram_en=%b required 0 0", busy, ram_en);
    else passed++;
  endtask

  task automatic test_rst_mid_burst();
    int got = 0;
    bit hit = 0;
    @(negedge clk); start = 1; start_addr = 14'h10; len = 15'd8;
    @(negedge clk); start = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      #1;
      if (out_valid && got == 2) hit = 1;
      else begin
        if (out_valid) got++;
        @(negedge clk);
      end
    end
    rst = 1; #1;
    total++;
    if (!hit || busy !== 0 || done !== 0 || ram_en !== 0 || ram_addr !== 0 || out_valid !== 0 || out_data !== 0)
      $display("FAIL rst_mid reached=%b busy=%b ram_en=%b ram_addr=%h valid=%b data=%h required all 0",
               hit, busy, ram_en, ram_addr, out_valid, out_data);
    else passed++;
    $display("reset asserted at word %0d", got);
    @(negedge clk); rst = 0;
    @(negedge clk); start = 1; start_addr = 14'h20; len = 15'd2;
    @(negedge clk); start = 0;
    expect_stream(32'h20, 2, "after_rst");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start = 1; start_addr = 14'h40; len = 15'd2;
    @(negedge clk); start = 0;
    expect_stream(32'h40, 2, "b2b_a");
    // still in the done cycle: the next command must be accepted here
    start = 1; start_addr = 14'h48; len = 15'd2;
    @(negedge clk); start = 0; #1;
    total++;
    if (busy !== 1 || ram_en !== 1 || ram_addr !== 14'h48)
      $display("FAIL b2b_accept busy=%b ram_en=%b addr=%h required 1 1 0048", busy, ram_en, ram_addr);
    else passed++;
    expect_stream(32'h48, 2, "b2b_b");
  endtask

`ifdef RAM_RD_STREAM_LAST_EN
  task automatic test_out_last();
    for (int t = 0; t < 2; t++) begin
      int n = (t == 0) ? 3 : 1;
      int got = 0;
      bit fin = 0;
      @(negedge clk); start = 1; start_addr = 14'h60; len = 15'(n);
      @(negedge clk); start = 0;
      for (int c = 0; c < 20 && !fin; c++) begin
        #1;
        if (done) fin = 1;
        else begin
          if (out_valid) begin
            total++;
            if (out_last !== (got == n - 1))
              $display("FAIL out_last len=%0d word=%0d got=%b required=%b", n, got, out_last, (got == n - 1));
            else passed++;
            $display("last len=%0d word %0d last=%b", n, got, out_last);
            got++;
          end
          @(negedge clk);
        end
      end
      total++;
      if (!fin || got !== n) $display("FAIL out_last_count len=%0d got=%0d required=%0d", n, got, n);
      else passed++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'(i);
    for (int i = 0; i < 16; i++) w_mem[i] = 32'hA0 + 32'(i);
    test_reset();
    test_burst();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_start_while_busy();
    test_rst_mid_burst();
    test_back_to_back();
`ifdef RAM_RD_STREAM_LAST_EN
    test_out_last();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
